// File: rtl/tree_pkg.sv
// Shared constants and types for the decision-tree frame loader and its helpers.
package tree_pkg;

  localparam int FEAT_W          = 51;
  localparam int BYTE_W          = 8;
  localparam int N_CLASS         = 7;
  localparam int CLASS_W         = 3;

  // Number of stream bytes needed to cover one feature vector (ceiling division).
  localparam int BYTES_PER_FRAME = (FEAT_W + BYTE_W - 1) / BYTE_W;

  // Bits held in the assembly register: every byte except the final one.
  localparam int ASM_W           = (BYTES_PER_FRAME - 1) * BYTE_W;

  // Bits of the final byte that land in the feature vector; the rest are ignored.
  localparam int TOP_W           = FEAT_W - ASM_W;

  localparam int CNT_W           = $clog2(BYTES_PER_FRAME);

  // Class code reported when no tree votes.
  localparam logic [CLASS_W-1:0] NO_VOTE = CLASS_W'(N_CLASS);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    EVAL  = 2'd1,
    OUT   = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/tree_vote_encoder.sv
// Priority encoder: lowest-index set vote wins, NO_VOTE when no bit is set.
module tree_vote_encoder
  import tree_pkg::*;
(
  input  logic [N_CLASS-1:0] votes,
  output logic [CLASS_W-1:0] win_idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    win_idx = NO_VOTE;
    for (int k = N_CLASS - 1; k >= 0; k--) begin
      if (votes[k]) begin
        win_idx = CLASS_W'(k);
      end
    end
  end

endmodule

// File: rtl/tree_frame_loader.sv
// Assembles byte-stream feature frames, presents them to the class trees,
// captures the votes one cycle later and returns the winning class.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Senders hold valid and payload stable until that edge;
// ready may toggle freely and never depends combinationally on valid.
module tree_frame_loader
  import tree_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [BYTE_W-1:0]  s_data,
  input  logic               s_last,
  output logic [FEAT_W-1:0]  feat_o,
  input  logic [N_CLASS-1:0] vote_i,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [CLASS_W-1:0] m_class,
  output logic [N_CLASS-1:0] m_votes,
  output logic               err_o
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_FRAME - 1);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [ASM_W-1:0]   asm_q;
  logic               accept;
  logic               load_frame;
  logic               err_next;
  logic               cnt_clear;
  logic               cnt_inc;
  logic               store;
  logic [CLASS_W-1:0] win_idx;

  // Only the two byte-consuming states take input; held off during reset.
  assign s_ready = !rst && ((state == LOAD) || (state == DRAIN));
  assign accept  = s_valid && s_ready;

  tree_vote_encoder u_enc (
    .votes   (vote_i),
    .win_idx (win_idx)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_next = state;
    load_frame = 1'b0;
    err_next   = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    store      = 1'b0;
    case (state)
      LOAD: begin
        if (accept) begin
          if (s_last) begin
            cnt_clear = 1'b1;
            if (cnt == LAST_IDX) begin
              load_frame = 1'b1;
              state_next = EVAL;
            end else begin
              err_next = 1'b1;   // frame too short: drop it, stay in LOAD
            end
          end else if (cnt == LAST_IDX) begin
            err_next   = 1'b1;   // frame too long: discard up to the next s_last
            cnt_clear  = 1'b1;
            state_next = DRAIN;
          end else begin
            store   = 1'b1;
            cnt_inc = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (accept && s_last) begin
          state_next = LOAD;
        end
      end
      EVAL: begin
        state_next = OUT;
      end
      OUT: begin
        if (m_ready) begin
          state_next = LOAD;
        end
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  // Byte counter and private assembly register; feat_o only moves on a complete frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      asm_q  <= '0;
      feat_o <= '0;
      err_o  <= 1'b0;
    end else begin
      err_o <= err_next;
      if (cnt_clear) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (store) begin
        for (int i = 0; i < BYTES_PER_FRAME - 1; i++) begin
          if (cnt == CNT_W'(i)) begin
            asm_q[i*BYTE_W +: BYTE_W] <= s_data;
          end
        end
      end
      if (load_frame) begin
        feat_o <= {s_data[TOP_W-1:0], asm_q};
      end
    end
  end

  // Result channel: capture votes after the settle cycle, hold until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_class <= '0;
      m_votes <= '0;
    end else if (state == EVAL) begin
      m_valid <= 1'b1;
      m_class <= win_idx;
      m_votes <= vote_i;
    end else if ((state == OUT) && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tree_frame_loader.sv
// Directed and randomized frames for tree_frame_loader, checked against a
// frame-level model of byte placement, framing errors and vote encoding.
module tb_tree_frame_loader;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic [50:0] feat_o;
  logic [6:0]  vote_i;
  logic        m_valid;
  logic        m_ready;
  logic [2:0]  m_class;
  logic [6:0]  m_votes;
  logic        err_o;

  int          errors = 0;
  int          checks = 0;
  logic [50:0] exp_feat;
  logic [7:0]  frame_b [0:15];

  tree_frame_loader dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .feat_o  (feat_o),
    .vote_i  (vote_i),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_class (m_class),
    .m_votes (m_votes),
    .err_o   (err_o)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: feature value built from the byte positions of a 7-byte frame.
  function automatic logic [50:0] model_feat();
    logic [63:0] acc;
    acc = 64'd0;
    for (int i = 0; i < 6; i++) acc = acc + (64'(frame_b[i]) << (8 * i));
    acc = acc + (64'(frame_b[6] % 8) << 48);
    return acc[50:0];
  endfunction

  // Reference model: lowest voting class, 7 when nobody votes.
  function automatic int model_class(input logic [6:0] v);
    for (int k = 0; k < 7; k++) if (v[k]) return k;
    return 7;
  endfunction

  // Driver: present one byte and wait (bounded) for it to be accepted.
  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    while (!s_ready && n < 50) begin
      step();
      n++;
    end
    check("s_ready_wait", 64'(s_ready), 64'd1);
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
  endtask

  // Send frame_b[0..n-1] with s_last on the final byte; hold result for 'hold' cycles.
  task automatic run_frame(input int n, input logic [6:0] votes, input int hold);
    int          err_idx;
    logic [50:0] f;
    err_idx = (n < 7) ? n - 1 : ((n > 7) ? 6 : -1);
    f       = model_feat();
    vote_i  = votes;
    m_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      send_byte(frame_b[i], (i == n - 1));
      check("err_pulse", 64'(err_o), 64'(i == err_idx));
      if (i < n - 1) check("no_result_mid", 64'(m_valid), 64'd0);
    end
    if (n == 7) begin
      exp_feat = f;
      check("feat", 64'(feat_o), 64'(exp_feat));
      check("eval_valid_low", 64'(m_valid), 64'd0);
      check("eval_ready_low", 64'(s_ready), 64'd0);
      step();
      check("m_valid_rise", 64'(m_valid), 64'd1);
      check("m_class", 64'(m_class), 64'(model_class(votes)));
      check("m_votes", 64'(m_votes), 64'(votes));
      for (int h = 0; h < hold; h++) begin
        step();
        check("hold_valid", 64'(m_valid), 64'd1);
        check("hold_class", 64'(m_class), 64'(model_class(votes)));
        check("hold_votes", 64'(m_votes), 64'(votes));
        check("hold_ready", 64'(s_ready), 64'd0);
      end
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      check("m_valid_fall", 64'(m_valid), 64'd0);
      check("back_to_load", 64'(s_ready), 64'd1);
    end else begin
      step();
      check("err_single", 64'(err_o), 64'd0);
      check("bad_no_result", 64'(m_valid), 64'd0);
      check("bad_feat_kept", 64'(feat_o), 64'(exp_feat));
      check("bad_ready", 64'(s_ready), 64'd1);
    end
  endtask

  task automatic check_reset_values();
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_class", 64'(m_class), 64'd0);
    check("rst_m_votes", 64'(m_votes), 64'd0);
    check("rst_feat", 64'(feat_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    s_last   = 1'b0;
    vote_i   = 7'd0;
    m_ready  = 1'b0;
    exp_feat = '0;
    repeat (3) step();
    check_reset_values();
    rst = 1'b0;
    step();
    check("ready_after_rst", 64'(s_ready), 64'd1);

    // Step 1: basic frame 01..07, class 2.
    for (int i = 0; i < 7; i++) frame_b[i] = 8'(i + 1);
    run_frame(7, 7'b0100100, 0);
    check("feat_const", 64'(feat_o), 64'h7_0605_0403_0201);

    // Step 2: top byte 0xFF, only its low 3 bits land.
    frame_b[6] = 8'hFF;
    run_frame(7, 7'b1000000, 0);
    check("feat_top_bits", 64'(feat_o[50:48]), 64'd7);

    // Step 3: short frame (s_last on byte 3), then a clean frame.
    for (int i = 0; i < 7; i++) frame_b[i] = 8'hA0 + 8'(i);
    run_frame(4, 7'b0000001, 0);
    run_frame(7, 7'b0010000, 0);

    // Step 4: long frame, 9 bytes, drained.
    for (int i = 0; i < 9; i++) frame_b[i] = 8'h30 + 8'(i);
    run_frame(9, 7'b0000010, 0);

    // Step 5: no votes, result held off for 5 cycles.
    for (int i = 0; i < 7; i++) frame_b[i] = 8'h5A ^ 8'(i);
    run_frame(7, 7'b0000000, 5);

    // Step 6: reset after byte 4 of a frame, then a full frame from byte 0.
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), 1'b0);
    #2;
    rst = 1'b1;
    #2;
    check_reset_values();
    exp_feat = '0;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 7; i++) frame_b[i] = 8'h11 * 8'(i + 1);
    run_frame(7, 7'b0001100, 1);

    // Step 7: randomized frames, lengths, votes and back-pressure.
    for (int it = 0; it < 30; it++) begin
      n = ($urandom_range(0, 9) < 7) ? 7 : int'($urandom_range(1, 10));
      for (int i = 0; i < 16; i++) frame_b[i] = 8'($urandom);
      run_frame(n, ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
